// File: rtl/dc_pkg.sv
// dc_pkg: shared constants and FSM state type for the data-cursor file
package dc_pkg;

    localparam int DC_COUNT     = 4;
    localparam int DC_SEL_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } dc_state_t;

endpackage

// File: rtl/dc_cursor.sv
// dc_cursor: one data-cursor address register with direction bit, loadable and steppable
module dc_cursor #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  load_dir,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic dir;

    // load wins over step; stepping wraps naturally modulo 2^ADDR_WIDTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr <= '0;
            dir  <= 1'b0;
        end else if (load) begin
            addr <= load_addr;
            dir  <= load_dir;
        end else if (step) begin
            addr <= dir ? addr - 1'b1 : addr + 1'b1;
        end
    end

endmodule

// File: rtl/dc_cursor_file.sv
// dc_cursor_file: four data cursors turning DC ops into single-beat memory requests
module dc_cursor_file
    import dc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic                    advance_read,
    input  logic                    advance_write,
    input  logic                    set,
    input  logic                    set_direction,
    input  logic [DC_SEL_WIDTH-1:0] choice,
    input  logic [ADDR_WIDTH-1:0]   set_address,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_rdata_vld,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data
);

    dc_state_t             state;
    dc_state_t             state_next;
    logic                  accept;
    logic                  do_set;
    logic                  do_adv;
    logic                  rd_done;
    logic [ADDR_WIDTH-1:0] cur_addr [DC_COUNT];
    logic [ADDR_WIDTH-1:0] sel_addr;

    // set outranks any advance in the same op; write outranks read
    assign accept   = op_valid & op_ready;
    assign do_set   = accept & set;
    assign do_adv   = accept & ~set & (advance_write | advance_read);
    assign sel_addr = cur_addr[choice];
    assign rd_done  = (state == WAIT_RD) & mem_rdata_vld;

    for (genvar g = 0; g < DC_COUNT; g++) begin : g_cur
        dc_cursor #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_cursor (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (do_set & (choice == DC_SEL_WIDTH'(g))),
            .step     (do_adv & (choice == DC_SEL_WIDTH'(g))),
            .load_addr(set_address),
            .load_dir (set_direction),
            .addr     (cur_addr[g])
        );
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // next-state logic: one outstanding memory op at a time
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = do_adv ? REQ : IDLE;
            REQ:     state_next = mem_req_ready ? (mem_we ? IDLE : WAIT_RD) : REQ;
            WAIT_RD: state_next = mem_rdata_vld ? IDLE : WAIT_RD;
            default: state_next = IDLE;
        endcase
    end

    // state-decoded handshake outputs
    always_comb begin
        op_ready      = (state == IDLE);
        mem_req_valid = (state == REQ);
    end

    // request fields captured at accept and held stable through REQ
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (do_adv) begin
            mem_we    <= advance_write;
            mem_addr  <= sel_addr;
            mem_wdata <= write_data;
        end
    end

    // read response capture; responses outside WAIT_RD are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= rd_done;
            if (rd_done) read_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dc_cursor_file.sv
// tb_dc_cursor_file: directed and randomized checks of dc_cursor_file against a cursor-array model
module tb_dc_cursor_file;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic          advance_read = 1'b0;
    logic          advance_write = 1'b0;
    logic          set = 1'b0;
    logic          set_direction = 1'b0;
    logic [1:0]    choice = 2'd0;
    logic [AW-1:0] set_address = '0;
    logic [DW-1:0] write_data = '0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdata_vld = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          read_valid;
    logic [DW-1:0] read_data;

    int n_checks = 0;
    int n_fail = 0;

    logic [AW-1:0] m_addr [4];
    logic          m_dir  [4];

    dc_cursor_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .advance_read (advance_read),
        .advance_write(advance_write),
        .set          (set),
        .set_direction(set_direction),
        .choice       (choice),
        .set_address  (set_address),
        .write_data   (write_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata_vld(mem_rdata_vld),
        .mem_rdata    (mem_rdata),
        .read_valid   (read_valid),
        .read_data    (read_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0;
            m_dir[i]  = 1'b0;
        end
    endtask

    task automatic check_cursors();
        check("cursor0", u_dut.g_cur[0].u_cursor.addr, m_addr[0]);
        check("cursor1", u_dut.g_cur[1].u_cursor.addr, m_addr[1]);
        check("cursor2", u_dut.g_cur[2].u_cursor.addr, m_addr[2]);
        check("cursor3", u_dut.g_cur[3].u_cursor.addr, m_addr[3]);
    endtask

    // drive one op, play the memory side, and compare everything against the model
    task automatic run_op(input logic s, input logic w, input logic r, input logic d,
                          input logic [1:0] ch, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rd);
        logic [AW-1:0] exp_addr;
        check("op_ready_idle", op_ready, 1);
        op_valid = 1; set = s; advance_write = w; advance_read = r;
        set_direction = d; choice = ch; set_address = a; write_data = wd;
        tick();
        op_valid = 0; set = 0; advance_write = 0; advance_read = 0;
        if (s) begin
            m_addr[ch] = a;
            m_dir[ch]  = d;
            check("set_no_req", mem_req_valid, 0);
            check("set_ready", op_ready, 1);
        end else if (w || r) begin
            exp_addr = m_addr[ch];
            m_addr[ch] = m_dir[ch] ? m_addr[ch] - 1 : m_addr[ch] + 1;
            for (int k = 0; k <= rdy_dly; k++) begin
                check("req_valid", mem_req_valid, 1);
                check("req_addr", mem_addr, exp_addr);
                check("req_we", mem_we, w);
                if (w) check("req_wdata", mem_wdata, wd);
                check("busy_req", op_ready, 0);
                if (k == rdy_dly) mem_req_ready = 1;
                tick();
            end
            mem_req_ready = 0;
            check("req_dropped", mem_req_valid, 0);
            if (r && !w) begin
                for (int k = 0; k < rsp_dly; k++) begin
                    check("busy_wait", op_ready, 0);
                    check("no_early_rv", read_valid, 0);
                    tick();
                end
                mem_rdata_vld = 1; mem_rdata = rd;
                tick();
                mem_rdata_vld = 0;
                check("read_valid", read_valid, 1);
                check("read_data", read_data, rd);
                check("ready_after_rd", op_ready, 1);
                tick();
                check("read_valid_pulse", read_valid, 0);
            end else begin
                check("ready_after_wr", op_ready, 1);
            end
        end else begin
            check("noop_no_req", mem_req_valid, 0);
            check("noop_ready", op_ready, 1);
        end
        check_cursors();
    endtask

    initial begin
        logic          s, w, r, d;
        logic [1:0]    ch;
        logic [AW-1:0] a;
        model_reset();
        tick();
        tick();
        check("rst_op_ready", op_ready, 1);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_read_data", read_data, 0);
        check_cursors();
        reset_n = 1;
        tick();

        run_op(1, 0, 0, 0, 2, 32'h100, 0, 0, 0, 0);
        run_op(0, 0, 1, 0, 2, 0, 0, 0, 1, 32'h1234);
        check("cursor2_fwd", u_dut.g_cur[2].u_cursor.addr, 32'h101);

        run_op(1, 0, 0, 1, 1, 32'h0, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 1, 0, 32'hAB, 0, 0, 0);
        check("cursor1_wrap_down", u_dut.g_cur[1].u_cursor.addr, 32'hFFFF_FFFF);

        run_op(0, 0, 1, 0, 2, 0, 0, 3, 0, 32'h5A5A);
        run_op(0, 0, 1, 0, 2, 0, 0, 0, 2, 32'hDEAD);

        run_op(1, 1, 0, 1, 3, 32'h55, 32'h77, 0, 0, 0);
        check("set_win_cursor3", u_dut.g_cur[3].u_cursor.addr, 32'h55);

        run_op(1, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_op(0, 1, 0, 0, 0, 0, 32'h1, 1, 0, 0);
        check("cursor0_wrap_up", u_dut.g_cur[0].u_cursor.addr, 32'h0);

        mem_rdata_vld = 1; mem_rdata = 32'hBAD;
        tick();
        mem_rdata_vld = 0;
        check("stray_rdata_ignored", read_valid, 0);
        check("stray_rdata_held", read_data, 32'hDEAD);

        run_op(1, 0, 0, 0, 2, 32'h40, 0, 0, 0, 0);
        op_valid = 1; advance_read = 1; choice = 2;
        tick();
        op_valid = 0; advance_read = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        check("in_wait_rd", op_ready, 0);
        reset_n = 0;
        #1;
        check("rst_async_ready", op_ready, 1);
        check("rst_async_rv", read_valid, 0);
        tick();
        reset_n = 1;
        model_reset();
        mem_rdata_vld = 1; mem_rdata = 32'hCAFE;
        tick();
        mem_rdata_vld = 0;
        check("late_resp_ignored", read_valid, 0);
        check("late_resp_data", read_data, 0);
        check("late_resp_ready", op_ready, 1);
        check("late_resp_noreq", mem_req_valid, 0);
        check_cursors();

        for (int n = 0; n < 300; n++) begin
            s  = ($urandom_range(0, 3) == 0);
            w  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 1) == 0);
            d  = 1'($urandom_range(0, 1));
            ch = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = '1;
                2:       a = 32'($urandom);
                default: a = 32'($urandom_range(0, 3));
            endcase
            run_op(s, w, r, d, ch, a, 32'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), 32'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
